// File: rtl/bus_reader.sv
// Round-robin reader for a shared tri-state bus: enables one source's buffer,
// waits SETTLE cycles for the bus to settle, then captures the word and acks the source.
module bus_reader #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] bus_in,
    output logic [3:0]  drv_en,
    output logic [31:0] data_out,
    output logic [1:0]  src_id,
    output logic        valid,
    output logic [3:0]  ack,
    output logic        busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [1:0]  grant_r, grant_s;
    logic [1:0]  last_grant_r, last_grant_s;
    logic [3:0]  drv_en_s;
    logic [31:0] data_out_s;
    logic [1:0]  src_id_s;
    logic        valid_s;
    logic [3:0]  ack_s;
    logic        busy_s;
    logic [3:0]  eff_s;

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        onehot = 4'b0001 << idx;
    endfunction

    // Search last+1 .. last+4 (mod 4); the first requesting source wins.
    function automatic logic [1:0] rr_pick(input logic [3:0] eff, input logic [1:0] last);
        logic [1:0] idx;
        logic       found;
        rr_pick = last;
        found   = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + k[1:0];
            if (!found && eff[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end else begin
                found = found;
            end
        end
    endfunction

    // A source being acked this cycle is masked so it cannot win again immediately.
    assign eff_s = req & ~ack;

    // Next-state and next-output logic.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        grant_s      = grant_r;
        last_grant_s = last_grant_r;
        drv_en_s     = drv_en;
        data_out_s   = data_out;
        src_id_s     = src_id;
        valid_s      = 1'b0;
        ack_s        = 4'b0000;
        case (state_r)
            IDLE: begin
                if (eff_s != 4'b0000) begin
                    grant_s  = rr_pick(eff_s, last_grant_r);
                    drv_en_s = onehot(grant_s);
                    cnt_s    = SETTLE_C;
                    state_s  = DRIVE;
                end else begin
                    drv_en_s = 4'b0000;
                end
            end
            DRIVE: begin
                if (cnt_r != 4'd0) begin
                    cnt_s = cnt_r - 4'd1;
                end else begin
                    data_out_s   = bus_in;
                    src_id_s     = grant_r;
                    last_grant_s = grant_r;
                    valid_s      = 1'b1;
                    ack_s        = onehot(grant_r);
                    drv_en_s     = 4'b0000;
                    state_s      = IDLE;
                end
            end
            default: begin
                state_s  = IDLE;
                drv_en_s = 4'b0000;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and output registers; reset drops the bus enable immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            grant_r      <= 2'd0;
            last_grant_r <= 2'd3;
            drv_en       <= 4'b0000;
            data_out     <= 32'h0000_0000;
            src_id       <= 2'd0;
            valid        <= 1'b0;
            ack          <= 4'b0000;
            busy         <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            grant_r      <= grant_s;
            last_grant_r <= last_grant_s;
            drv_en       <= drv_en_s;
            data_out     <= data_out_s;
            src_id       <= src_id_s;
            valid        <= valid_s;
            ack          <= ack_s;
            busy         <= busy_s;
        end
    end

endmodule

// File: tb/tb_bus_reader.sv
// Directed bench for bus_reader: three instances cover SETTLE = 1, 3 and 0.
module tb_bus_reader;

    logic        clk = 1'b0;
    logic [31:0] sd [4];

    logic        rst_a, rst_b, rst_c;
    logic [3:0]  req_a, req_b, req_c;
    logic [31:0] bus_a, bus_b, bus_c;
    logic [3:0]  drv_a, drv_b, drv_c;
    logic [31:0] dout_a, dout_b, dout_c;
    logic [1:0]  sid_a, sid_b, sid_c;
    logic        val_a, val_b, val_c;
    logic [3:0]  ack_a, ack_b, ack_c;
    logic        busy_a, busy_b, busy_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] bus_of(input logic [3:0] en);
        case (en)
            4'b0001: bus_of = sd[0];
            4'b0010: bus_of = sd[1];
            4'b0100: bus_of = sd[2];
            4'b1000: bus_of = sd[3];
            default: bus_of = 32'hzzzz_zzzz;
        endcase
    endfunction

    assign bus_a = bus_of(drv_a);
    assign bus_b = bus_of(drv_b);
    assign bus_c = bus_of(drv_c);

    bus_reader #(.SETTLE(1)) dut_a (
        .clk(clk), .reset(rst_a), .req(req_a), .bus_in(bus_a), .drv_en(drv_a),
        .data_out(dout_a), .src_id(sid_a), .valid(val_a), .ack(ack_a), .busy(busy_a)
    );
    bus_reader #(.SETTLE(3)) dut_b (
        .clk(clk), .reset(rst_b), .req(req_b), .bus_in(bus_b), .drv_en(drv_b),
        .data_out(dout_b), .src_id(sid_b), .valid(val_b), .ack(ack_b), .busy(busy_b)
    );
    bus_reader #(.SETTLE(0)) dut_c (
        .clk(clk), .reset(rst_c), .req(req_c), .bus_in(bus_c), .drv_en(drv_c),
        .data_out(dout_c), .src_id(sid_c), .valid(val_c), .ack(ack_c), .busy(busy_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        req_a = 4'b0; req_b = 4'b0; req_c = 4'b0;
        sd[0] = 32'h0000_0001; sd[1] = 32'h1111_1111;
        sd[2] = 32'h1234_5678; sd[3] = 32'hDEAD_BEEF;
        tick();
        tick();
        chk("rst_drv", {28'd0, drv_a}, 32'd0);
        chk("rst_valid", {31'd0, val_a}, 32'd0);
        chk("rst_ack", {28'd0, ack_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_data", dout_a, 32'h0);
        chk("rst_sid", {30'd0, sid_a}, 32'd0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        // Single transfer, SETTLE=1; req drops mid-drive without aborting.
        req_a = 4'b0001;
        tick();
        chk("single_drv1", {28'd0, drv_a}, 32'h1);
        chk("single_busy", {31'd0, busy_a}, 32'd1);
        chk("single_val_early", {31'd0, val_a}, 32'd0);
        req_a = 4'b0000;
        tick();
        chk("single_drv2", {28'd0, drv_a}, 32'h1);
        tick();
        chk("single_drv_off", {28'd0, drv_a}, 32'h0);
        chk("single_valid", {31'd0, val_a}, 32'd1);
        chk("single_ack", {28'd0, ack_a}, 32'h1);
        chk("single_data", dout_a, 32'h0000_0001);
        chk("single_sid", {30'd0, sid_a}, 32'd0);
        tick();
        chk("single_valid_pulse", {31'd0, val_a}, 32'd0);
        chk("single_ack_pulse", {28'd0, ack_a}, 32'h0);
        chk("single_hold", dout_a, 32'h0000_0001);

        // Walking-one data from source 2.
        for (int i = 0; i < 32; i++) begin
            sd[2] = 32'h1 << i;
            req_a = 4'b0100;
            tick();
            req_a = 4'b0000;
            tick();
            tick();
            chk($sformatf("walk_data%0d", i), dout_a, 32'h1 << i);
            chk($sformatf("walk_sid%0d", i), {30'd0, sid_a}, 32'd2);
            chk($sformatf("walk_known%0d", i), {31'd0, $isunknown(dout_a)}, 32'd0);
            tick();
        end

        // Round-robin from a fresh reset with all sources requesting.
        rst_a = 1'b1;
        #1;
        rst_a = 1'b0;
        req_a = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("rr_drv%0d", k), {28'd0, drv_a}, 32'h1 << (k % 4));
            chk($sformatf("rr_noval%0d", k), {31'd0, val_a}, 32'd0);
            tick();
            chk($sformatf("rr_drv_hold%0d", k), {28'd0, drv_a}, 32'h1 << (k % 4));
            tick();
            chk($sformatf("rr_valid%0d", k), {31'd0, val_a}, 32'd1);
            chk($sformatf("rr_sid%0d", k), {30'd0, sid_a}, k % 4);
            chk($sformatf("rr_ack%0d", k), {28'd0, ack_a}, 32'h1 << (k % 4));
            chk($sformatf("rr_drv_idle%0d", k), {28'd0, drv_a}, 32'h0);
        end
        req_a = 4'b0000;
        tick();
        chk("rr_end_valid", {31'd0, val_a}, 32'd0);
        chk("rr_end_busy", {31'd0, busy_a}, 32'd0);

        // Ack masking: source 2 held, not re-granted during its own ack cycle.
        sd[2] = 32'hCAFE_0002;
        req_a = 4'b0100;
        tick();
        chk("mask_drv", {28'd0, drv_a}, 32'h4);
        tick();
        tick();
        chk("mask_valid", {31'd0, val_a}, 32'd1);
        chk("mask_ack", {28'd0, ack_a}, 32'h4);
        chk("mask_data", dout_a, 32'hCAFE_0002);
        tick();
        chk("mask_no_regrant", {28'd0, drv_a}, 32'h0);
        chk("mask_idle", {31'd0, busy_a}, 32'd0);
        tick();
        chk("mask_regrant", {28'd0, drv_a}, 32'h4);
        req_a = 4'b0000;
        tick();
        tick();
        chk("mask_valid2", {31'd0, val_a}, 32'd1);

        // Reset mid-DRIVE, SETTLE=3.
        req_b = 4'b0100;
        tick();
        chk("rstmid_drv1", {28'd0, drv_b}, 32'h4);
        req_b = 4'b0000;
        tick();
        chk("rstmid_drv2", {28'd0, drv_b}, 32'h4);
        rst_b = 1'b1;
        #1;
        chk("rstmid_async_drv", {28'd0, drv_b}, 32'h0);
        chk("rstmid_async_busy", {31'd0, busy_b}, 32'd0);
        #1;
        rst_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rstmid_noval%0d", k), {31'd0, val_b}, 32'd0);
            chk($sformatf("rstmid_data%0d", k), dout_b, 32'h0);
        end
        req_b = 4'b1111;
        tick();
        chk("rstmid_next_src0", {28'd0, drv_b}, 32'h1);
        req_b = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("s3_drv%0d", k), {28'd0, drv_b}, 32'h1);
        end
        tick();
        chk("s3_valid", {31'd0, val_b}, 32'd1);
        chk("s3_sid", {30'd0, sid_b}, 32'd0);
        chk("s3_data", dout_b, 32'h0000_0001);

        // SETTLE=0 boundary.
        req_c = 4'b1000;
        tick();
        chk("s0_drv", {28'd0, drv_c}, 32'h8);
        req_c = 4'b0000;
        tick();
        chk("s0_drv_off", {28'd0, drv_c}, 32'h0);
        chk("s0_valid", {31'd0, val_c}, 32'd1);
        chk("s0_ack", {28'd0, ack_c}, 32'h8);
        chk("s0_data", dout_c, 32'hDEAD_BEEF);
        chk("s0_sid", {30'd0, sid_c}, 32'd3);
        tick();
        chk("s0_valid_pulse", {31'd0, val_c}, 32'd0);
        chk("s0_hold", dout_c, 32'hDEAD_BEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // One-hot enable invariant on every cycle of every instance.
    always @(negedge clk) begin
        if (!$onehot0(drv_a) || !$onehot0(drv_b) || !$onehot0(drv_c)) begin
            chk("onehot", {20'd0, drv_c, drv_b, drv_a}, 32'h0);
        end
    end

endmodule
